// File: rtl/sa_pkg.sv
// Shared encodings for the systolic-array host controller: bus regions, register map,
// STATUS bit positions, controller states and the run timeout.
package sa_pkg;

   typedef enum logic [1:0] {
      RGN_WGT = 2'b00,
      RGN_INP = 2'b01,
      RGN_RES = 2'b10,
      RGN_CSR = 2'b11
   } region_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   localparam int unsigned OFF_CTRL   = 0;
   localparam int unsigned OFF_STATUS = 1;
   localparam int unsigned OFF_IRQ_EN = 2;
   localparam int unsigned OFF_CYCLES = 3;

   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_CLR   = 1;
   localparam int unsigned CTRL_ACC   = 2;

   localparam int unsigned STS_BUSY     = 0;
   localparam int unsigned STS_DONE     = 1;
   localparam int unsigned STS_ERR_TMO  = 2;
   localparam int unsigned STS_ERR_OVF  = 3;
   localparam int unsigned STS_ERR_ADDR = 4;
   localparam int unsigned STS_ERR_BUSY = 5;

   // A run may take at most twice the array's fill-plus-drain latency.
   function automatic int unsigned tmo(input int unsigned rows, input int unsigned cols);
      return 2 * (2 * rows + cols);
   endfunction

endpackage

// File: rtl/sa_result_buf.sv
// Column-major result store: each column appends at its own pointer, optionally adding
// to the stored value; host side has one preload write port and one read port.
module sa_result_buf #(
   parameter int unsigned ROWS  = 8,
   parameter int unsigned COLS  = 8,
   parameter int unsigned MAC_W = 19,
   parameter int unsigned IDX_W = $clog2(ROWS * COLS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_ptr_i,
   input  logic                  run_i,
   input  logic                  acc_i,
   input  logic [COLS*MAC_W-1:0] mac_i,
   input  logic [COLS-1:0]       mac_v_i,
   input  logic                  host_we_i,
   input  logic [IDX_W-1:0]      host_idx_i,
   input  logic [MAC_W-1:0]      host_wdata_i,
   input  logic [IDX_W-1:0]      rd_idx_i,
   output logic [MAC_W-1:0]      rd_data_o,
   output logic                  full_o,
   output logic                  ovf_o
);

   localparam int unsigned PTR_W = $clog2(ROWS + 1);

   logic [MAC_W-1:0] mem_q [ROWS*COLS];
   logic [PTR_W-1:0] ptr_q [COLS];
   logic [PTR_W-1:0] ptr_d [COLS];
   logic [COLS-1:0]  col_we;
   logic [IDX_W-1:0] col_idx [COLS];
   logic [MAC_W-1:0] col_wdata [COLS];

   always_comb begin
      full_o = 1'b1;
      ovf_o  = 1'b0;
      col_we = '0;
      for (int unsigned c = 0; c < COLS; c++) begin
         ptr_d[c]     = ptr_q[c];
         // Entry (c, r) lives at flat index c*ROWS + r, matching the host offset map.
         col_idx[c]   = IDX_W'(c * ROWS + 32'(ptr_q[c]));
         col_wdata[c] = acc_i ? mem_q[col_idx[c]] + mac_i[c*MAC_W +: MAC_W]
                              : mac_i[c*MAC_W +: MAC_W];
         if (ptr_q[c] != PTR_W'(ROWS)) full_o = 1'b0;
         if (mac_v_i[c]) begin
            if (run_i && ptr_q[c] != PTR_W'(ROWS)) begin
               col_we[c] = 1'b1;
               ptr_d[c]  = ptr_q[c] + 1'b1;
            end else begin
               ovf_o = 1'b1;
            end
         end
         if (clr_ptr_i) ptr_d[c] = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int unsigned c = 0; c < COLS; c++) ptr_q[c] <= '0;
      end else begin
         for (int unsigned c = 0; c < COLS; c++) ptr_q[c] <= ptr_d[c];
      end
   end

   always_ff @(posedge clk_i) begin
      if (host_we_i) mem_q[host_idx_i] <= host_wdata_i;
      for (int unsigned c = 0; c < COLS; c++) begin
         if (col_we[c]) mem_q[col_idx[c]] <= col_wdata[c];
      end
   end

   assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/sa_host_ctrl.sv
// Bus-facing controller for the systolic array: forwards weight/input loads, sequences
// a run, collects column results and exposes status, interrupt and cycle count.
module sa_host_ctrl
   import sa_pkg::*;
#(
   parameter int unsigned ROWS   = 8,
   parameter int unsigned COLS   = 8,
   parameter int unsigned X_W    = 8,
   parameter int unsigned MAC_W  = 19,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic                  wr_vi,
   input  logic                  rd_vi,
   output logic [DATA_W-1:0]     rdata_o,
   output logic                  rdata_vo,
   output logic                  irq_o,
   output logic [X_W-1:0]        w_o,
   output logic [5:0]            w_addr_o,
   output logic                  w_en_o,
   output logic [X_W-1:0]        rbuf_wdata_o,
   output logic [5:0]            rbuf_waddr_o,
   output logic                  rbuf_w_vo,
   output logic                  start_vo,
   input  logic [COLS*MAC_W-1:0] mac_i,
   input  logic [COLS-1:0]       mac_v_i
);

   localparam int unsigned ENTRIES = ROWS * COLS;
   localparam int unsigned TMO     = tmo(ROWS, COLS);
   localparam int unsigned CNT_W   = $clog2(TMO + 1);
   localparam int unsigned IDX_W   = $clog2(ENTRIES);

   state_e            state_q, state_d;
   logic              acc_q, acc_d, irq_en_q, irq_en_d, start_q, start_d;
   logic              done_q, done_d, err_tmo_q, err_tmo_d, err_ovf_q, err_ovf_d;
   logic              err_addr_q, err_addr_d, err_busy_q, err_busy_d;
   logic              rdata_v_q, rdata_v_d;
   logic [DATA_W-1:0] rdata_q, rdata_d, rd_val;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cycles_q, cycles_d, cnt_inc;

   region_e           rgn;
   logic [31:0]       off32;
   logic              busy, idle, in_range, ctrl_wr, do_start, clr;
   logic              set_busy, set_addr, set_tmo, set_done, host_we;
   logic              buf_full, buf_ovf;
   logic [MAC_W-1:0]  buf_rdata;
   logic              unused_wdata;

   assign unused_wdata = ^wdata_i[DATA_W-1:MAC_W];

   always_comb begin
      rgn      = region_e'(addr_i[ADDR_W-1 -: 2]);
      off32    = 32'(addr_i[ADDR_W-3:0]);
      idle     = (state_q == S_IDLE);
      busy     = !idle;
      in_range = (off32 < ENTRIES);
      ctrl_wr  = wr_vi && rgn == RGN_CSR && off32 == OFF_CTRL;
      do_start = ctrl_wr && wdata_i[CTRL_START] && idle;
      clr      = ctrl_wr && wdata_i[CTRL_CLR];
      set_busy = wr_vi && busy && (rgn != RGN_CSR || (ctrl_wr && wdata_i[CTRL_START]));
      set_addr = wr_vi && idle && rgn != RGN_CSR && !in_range;
      host_we  = wr_vi && idle && rgn == RGN_RES && in_range;
   end

   assign w_en_o       = wr_vi && idle && rgn == RGN_WGT && in_range;
   assign w_addr_o     = off32[5:0];
   assign w_o          = wdata_i[X_W-1:0];
   assign rbuf_w_vo    = wr_vi && idle && rgn == RGN_INP && in_range;
   assign rbuf_waddr_o = off32[5:0];
   assign rbuf_wdata_o = wdata_i[X_W-1:0];

   sa_result_buf #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .MAC_W (MAC_W),
      .IDX_W (IDX_W)
   ) u_buf (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clr_ptr_i    (do_start),
      .run_i        (state_q == S_RUN),
      .acc_i        (acc_q),
      .mac_i        (mac_i),
      .mac_v_i      (mac_v_i),
      .host_we_i    (host_we),
      .host_idx_i   (off32[IDX_W-1:0]),
      .host_wdata_i (wdata_i[MAC_W-1:0]),
      .rd_idx_i     (off32[IDX_W-1:0]),
      .rd_data_o    (buf_rdata),
      .full_o       (buf_full),
      .ovf_o        (buf_ovf)
   );

   always_comb begin
      state_d  = state_q;
      start_d  = 1'b0;
      cnt_d    = cnt_q;
      cycles_d = cycles_q;
      acc_d    = acc_q;
      set_tmo  = 1'b0;
      set_done = 1'b0;
      cnt_inc  = (cnt_q == CNT_W'(TMO)) ? cnt_q : cnt_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (do_start) begin
               state_d = S_RUN;
               start_d = 1'b1;
               cnt_d   = '0;
               acc_d   = wdata_i[CTRL_ACC];
            end
         end
         S_RUN: begin
            cnt_d = cnt_inc;
            if (buf_full) begin
               state_d  = S_DONE;
               cycles_d = cnt_inc;
            end else if (cnt_inc == CNT_W'(TMO)) begin
               state_d  = S_DONE;
               cycles_d = cnt_inc;
               set_tmo  = 1'b1;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            set_done = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // A flag raised in the same cycle as a clear survives it.
      done_d     = (done_q & ~clr & ~do_start) | set_done;
      err_tmo_d  = (err_tmo_q & ~clr) | set_tmo;
      err_ovf_d  = (err_ovf_q & ~clr) | buf_ovf;
      err_addr_d = (err_addr_q & ~clr) | set_addr;
      err_busy_d = (err_busy_q & ~clr) | set_busy;
      irq_en_d   = (wr_vi && rgn == RGN_CSR && off32 == OFF_IRQ_EN) ? wdata_i[0] : irq_en_q;

      rd_val = '0;
      if (rgn == RGN_RES && in_range) begin
         rd_val = DATA_W'(buf_rdata);
      end else if (rgn == RGN_CSR) begin
         case (off32)
            OFF_STATUS: begin
               rd_val[STS_BUSY]     = busy;
               rd_val[STS_DONE]     = done_q;
               rd_val[STS_ERR_TMO]  = err_tmo_q;
               rd_val[STS_ERR_OVF]  = err_ovf_q;
               rd_val[STS_ERR_ADDR] = err_addr_q;
               rd_val[STS_ERR_BUSY] = err_busy_q;
            end
            OFF_IRQ_EN: rd_val[0] = irq_en_q;
            OFF_CYCLES: rd_val = DATA_W'(cycles_q);
            default:    rd_val = '0;
         endcase
      end
      rdata_d   = rd_vi ? rd_val : rdata_q;
      rdata_v_d = rd_vi;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         start_q    <= 1'b0;
         cnt_q      <= '0;
         cycles_q   <= '0;
         acc_q      <= 1'b0;
         irq_en_q   <= 1'b0;
         done_q     <= 1'b0;
         err_tmo_q  <= 1'b0;
         err_ovf_q  <= 1'b0;
         err_addr_q <= 1'b0;
         err_busy_q <= 1'b0;
         rdata_q    <= '0;
         rdata_v_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         cnt_q      <= cnt_d;
         cycles_q   <= cycles_d;
         acc_q      <= acc_d;
         irq_en_q   <= irq_en_d;
         done_q     <= done_d;
         err_tmo_q  <= err_tmo_d;
         err_ovf_q  <= err_ovf_d;
         err_addr_q <= err_addr_d;
         err_busy_q <= err_busy_d;
         rdata_q    <= rdata_d;
         rdata_v_q  <= rdata_v_d;
      end
   end

   assign start_vo = start_q;
   assign rdata_o  = rdata_q;
   assign rdata_vo = rdata_v_q;
   assign irq_o    = done_q & irq_en_q;

endmodule

// File: tb/tb_sa_host_ctrl.sv
// Directed bench for sa_host_ctrl on a 2x2 array: a vector table for bus decode and
// registers, then hand-written run sequences for the multi-cycle cases.
module tb_sa_host_ctrl;

   localparam int unsigned ROWS  = 2;
   localparam int unsigned COLS  = 2;
   localparam int unsigned MAC_W = 19;
   localparam int unsigned TMO   = 2 * (2 * ROWS + COLS);

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [9:0]        addr_i;
   logic [31:0]       wdata_i;
   logic              wr_vi, rd_vi;
   logic [31:0]       rdata_o;
   logic              rdata_vo, irq_o;
   logic [7:0]        w_o, rbuf_wdata_o;
   logic [5:0]        w_addr_o, rbuf_waddr_o;
   logic              w_en_o, rbuf_w_vo, start_vo;
   logic [2*MAC_W-1:0] mac_i;
   logic [1:0]        mac_v_i;

   int n_vec = 0;
   int n_err = 0;

   logic       s_wen, s_rben, s_start;
   logic [5:0] s_waddr, s_raddr;
   logic [7:0] s_w, s_rw;

   sa_host_ctrl #(
      .ROWS   (ROWS),
      .COLS   (COLS),
      .X_W    (8),
      .MAC_W  (MAC_W),
      .ADDR_W (10),
      .DATA_W (32)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .wr_vi        (wr_vi),
      .rd_vi        (rd_vi),
      .rdata_o      (rdata_o),
      .rdata_vo     (rdata_vo),
      .irq_o        (irq_o),
      .w_o          (w_o),
      .w_addr_o     (w_addr_o),
      .w_en_o       (w_en_o),
      .rbuf_wdata_o (rbuf_wdata_o),
      .rbuf_waddr_o (rbuf_waddr_o),
      .rbuf_w_vo    (rbuf_w_vo),
      .start_vo     (start_vo),
      .mac_i        (mac_i),
      .mac_v_i      (mac_v_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          rd;
      logic [9:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
      bit          wen;
      bit          rben;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk_i);
      addr_i = a; wdata_i = d; wr_vi = 1'b1;
      #1;
      s_wen = w_en_o; s_waddr = w_addr_o; s_w = w_o;
      s_rben = rbuf_w_vo; s_raddr = rbuf_waddr_o; s_rw = rbuf_wdata_o;
      @(posedge clk_i); #1;
      wr_vi = 1'b0;
      s_start = start_vo;
   endtask

   task automatic rd_chk(input string nm, input logic [9:0] a, input logic [31:0] exp);
      @(negedge clk_i);
      addr_i = a; rd_vi = 1'b1;
      @(posedge clk_i); #1;
      rd_vi = 1'b0;
      chk({nm, "_v"}, 32'(rdata_vo), 32'd1);
      chk(nm, rdata_o, exp);
   endtask

   task automatic mac_cyc(input logic [1:0] v, input logic [MAC_W-1:0] c0, input logic [MAC_W-1:0] c1);
      @(negedge clk_i);
      mac_v_i = v; mac_i = {c1, c0};
      @(posedge clk_i); #1;
      mac_v_i = '0;
   endtask

   task automatic wait_irq(input string nm, input int exp_n);
      int n = 0;
      while (irq_o !== 1'b1 && n < 40) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk(nm, 32'(n), 32'(exp_n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl [13];
      tbl[0]  = '{1, 10'h301, 32'h0,  32'h00, 0, 0};
      tbl[1]  = '{1, 10'h302, 32'h0,  32'h00, 0, 0};
      tbl[2]  = '{1, 10'h303, 32'h0,  32'h00, 0, 0};
      tbl[3]  = '{0, 10'h003, 32'hAB, 32'h03, 1, 0};
      tbl[4]  = '{0, 10'h101, 32'h55, 32'h01, 0, 1};
      tbl[5]  = '{0, 10'h004, 32'h77, 32'h00, 0, 0};
      tbl[6]  = '{1, 10'h301, 32'h0,  32'h10, 0, 0};
      tbl[7]  = '{0, 10'h300, 32'h2,  32'h00, 0, 0};
      tbl[8]  = '{1, 10'h301, 32'h0,  32'h00, 0, 0};
      tbl[9]  = '{0, 10'h302, 32'h1,  32'h00, 0, 0};
      tbl[10] = '{1, 10'h302, 32'h0,  32'h01, 0, 0};
      tbl[11] = '{1, 10'h000, 32'h0,  32'h00, 0, 0};
      tbl[12] = '{1, 10'h304, 32'h0,  32'h00, 0, 0};

      rst_i = 1'b0; addr_i = '0; wdata_i = '0; wr_vi = 1'b0; rd_vi = 1'b0;
      mac_i = '0; mac_v_i = '0;
      #1;
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_rdata_v", 32'(rdata_vo), 32'h0);
      chk("rst_start", 32'(start_vo), 32'h0);
      chk("rst_irq", 32'(irq_o), 32'h0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;

      for (int i = 0; i < 13; i++) begin
         if (tbl[i].rd) begin
            rd_chk($sformatf("vec%0d_rd", i), tbl[i].addr, tbl[i].exp);
         end else begin
            bus_wr(tbl[i].addr, tbl[i].data);
            chk($sformatf("vec%0d_wen", i), 32'(s_wen), 32'(tbl[i].wen));
            chk($sformatf("vec%0d_rben", i), 32'(s_rben), 32'(tbl[i].rben));
            if (tbl[i].wen) begin
               chk($sformatf("vec%0d_waddr", i), 32'(s_waddr), tbl[i].exp);
               chk($sformatf("vec%0d_wdata", i), 32'(s_w), tbl[i].data);
            end
            if (tbl[i].rben) begin
               chk($sformatf("vec%0d_raddr", i), 32'(s_raddr), tbl[i].exp);
               chk($sformatf("vec%0d_rwdata", i), 32'(s_rw), tbl[i].data);
            end
         end
      end

      // Normal run
      bus_wr(10'h300, 32'h1);
      chk("norm_start_pulse", 32'(s_start), 32'h1);
      @(posedge clk_i); #1;
      chk("norm_start_once", 32'(start_vo), 32'h0);
      mac_cyc(2'b11, 19'd5, 19'd7);
      mac_cyc(2'b11, 19'd6, 19'd8);
      wait_irq("norm_done_lat", 2);
      chk("norm_irq", 32'(irq_o), 32'h1);
      rd_chk("norm_status", 10'h301, 32'h02);
      rd_chk("norm_e0", 10'h200, 32'd5);
      rd_chk("norm_e1", 10'h201, 32'd6);
      rd_chk("norm_e2", 10'h202, 32'd7);
      rd_chk("norm_e3", 10'h203, 32'd8);
      bus_wr(10'h300, 32'h2);
      chk("norm_irq_clr", 32'(irq_o), 32'h0);

      // Overflow and busy
      bus_wr(10'h300, 32'h1);
      bus_wr(10'h000, 32'h11);
      chk("busy_wen", 32'(s_wen), 32'h0);
      mac_cyc(2'b11, 19'd1, 19'd3);
      mac_cyc(2'b11, 19'd2, 19'd4);
      mac_cyc(2'b01, 19'd9, 19'd0);
      wait_irq("ovf_done_lat", 1);
      rd_chk("ovf_status", 10'h301, 32'h2A);
      rd_chk("ovf_e0", 10'h200, 32'd1);
      rd_chk("ovf_e1", 10'h201, 32'd2);
      rd_chk("ovf_e2", 10'h202, 32'd3);
      rd_chk("ovf_e3", 10'h203, 32'd4);
      bus_wr(10'h300, 32'h2);

      // Accumulate with wrap
      bus_wr(10'h200, 32'd10);
      bus_wr(10'h201, 32'h7FFFF);
      rd_chk("acc_preload", 10'h200, 32'd10);
      bus_wr(10'h300, 32'h5);
      mac_cyc(2'b11, 19'd5, 19'd0);
      mac_cyc(2'b11, 19'd2, 19'd0);
      wait_irq("acc_done_lat", 2);
      rd_chk("acc_e0", 10'h200, 32'd15);
      rd_chk("acc_e1_wrap", 10'h201, 32'd1);
      rd_chk("acc_e2", 10'h202, 32'd3);
      rd_chk("acc_e3", 10'h203, 32'd4);
      rd_chk("acc_status", 10'h301, 32'h02);
      bus_wr(10'h300, 32'h2);

      // Timeout: one result per column only
      bus_wr(10'h300, 32'h1);
      mac_cyc(2'b11, 19'd11, 19'd12);
      rd_chk("tmo_busy", 10'h301, 32'h01);
      wait_irq("tmo_lat", int'(TMO) - 1);
      rd_chk("tmo_status", 10'h301, 32'h06);
      rd_chk("tmo_cycles", 10'h303, 32'(TMO));
      rd_chk("tmo_e0", 10'h200, 32'd11);
      rd_chk("tmo_e2", 10'h202, 32'd12);
      bus_wr(10'h300, 32'h2);

      // Reset in the middle of a run
      bus_wr(10'h300, 32'h1);
      mac_cyc(2'b01, 19'd20, 19'd0);
      @(negedge clk_i);
      rst_i = 1'b0; mac_v_i = 2'b11; mac_i = {19'd77, 19'd77};
      #1;
      chk("rrun_irq", 32'(irq_o), 32'h0);
      chk("rrun_start", 32'(start_vo), 32'h0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      mac_v_i = '0;
      rst_i = 1'b1;
      rd_chk("rrun_status", 10'h301, 32'h00);
      rd_chk("rrun_irq_en", 10'h302, 32'h00);
      rd_chk("rrun_cycles", 10'h303, 32'h00);
      rd_chk("rrun_e0", 10'h200, 32'd20);
      rd_chk("rrun_e2", 10'h202, 32'd12);
      chk("rrun_irq_after", 32'(irq_o), 32'h0);
      bus_wr(10'h302, 32'h1);
      bus_wr(10'h300, 32'h1);
      mac_cyc(2'b11, 19'd5, 19'd7);
      mac_cyc(2'b11, 19'd6, 19'd8);
      wait_irq("rrun2_done_lat", 2);
      rd_chk("rrun2_status", 10'h301, 32'h02);
      rd_chk("rrun2_e0", 10'h200, 32'd5);
      rd_chk("rrun2_e1", 10'h201, 32'd6);
      rd_chk("rrun2_e2", 10'h202, 32'd7);
      rd_chk("rrun2_e3", 10'h203, 32'd8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
